pipe_sequencer: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It turns hazard and event inputs from the IF/ID/EX/MEM stages into per-register stall and flush strobes. It owns the pending-interrupt latch and chooses the safe cycle at which the ID-stage decoder is told to inject an interrupt (its `IRQ` input). It sits beside the decoder; all pipeline registers take their enables and clears from here.

---
 rtl/pipe_sequencer_pkg.sv | 18 +
 rtl/pipe_sequencer_if.sv | 41 ++++
 rtl/pipe_sequencer_hazard_detect.sv | 16 +
 rtl/pipe_sequencer.sv | 121 ++++++++++++
 tb/tb_pipe_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_sequencer_pkg.sv
// Shared types for the pipeline sequencer: FSM state enum and the PCSrc
// encodings also used by the ID-stage decoder.
package pipe_seq_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        IRQ_HOLD = 2'd2
    } seq_state_e;

    localparam logic [2:0] PCSRC_SEQ = 3'd0;
    localparam logic [2:0] PCSRC_BR  = 3'd1;
    localparam logic [2:0] PCSRC_J   = 3'd2;
    localparam logic [2:0] PCSRC_JR  = 3'd3;
    localparam logic [2:0] PCSRC_IRQ = 3'd4;
    localparam logic [2:0] PCSRC_EXC = 3'd5;

endpackage

// File: rtl/pipe_sequencer_if.sv
// Hazard/event inputs and stall/flush/interrupt outputs of the sequencer.
// master = sequencer side, slave = pipeline side.
interface pipe_seq_if;

    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [2:0]  id_pcsrc;
    logic        ex_memrd;
    logic [4:0]  ex_rt;
    logic        ex_br_taken;
    logic        mem_busy;
    logic        irq_in;
    logic        pc31_id;

    logic        stall_if;
    logic        stall_id;
    logic        stall_ex;
    logic        stall_mem;
    logic        flush_id;
    logic        flush_ex;
    logic        irq_take;
    logic        irq_pend;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        input  id_rs, id_rt, id_uses_rt, id_pcsrc, ex_memrd, ex_rt,
               ex_br_taken, mem_busy, irq_in, pc31_id,
        output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
               irq_take, irq_pend, stall_cnt, flush_cnt
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, id_pcsrc, ex_memrd, ex_rt,
               ex_br_taken, mem_busy, irq_in, pc31_id,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
               irq_take, irq_pend, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_sequencer_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source
// registers of the instruction in ID.
module hazard_detect (
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       ex_memrd_i,
    input  logic [4:0] ex_rt_i,
    output logic       lu_o
);

    // $zero is never a real dependency
    assign lu_o = ex_memrd_i && (ex_rt_i != 5'd0) &&
                  ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencing controller: stall/flush strobes, pending-interrupt latch
// and interrupt-take timing. Define PIPE_SEQ_PERF_EN to build the perf counters.
module pipe_sequencer
    import pipe_seq_pkg::*;
#(
    parameter int unsigned HOLDOFF = 3
) (
    input  logic        clk,
    input  logic        reset,
    pipe_seq_if.master  pif
);

    seq_state_e state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic       irq_pend_q, irq_pend_d;
    logic       lu;

    logic stall_if, stall_id, stall_ex, stall_mem;
    logic flush_id, flush_ex, irq_take;

    hazard_detect u_hazard (
        .id_rs_i      (pif.id_rs),
        .id_rt_i      (pif.id_rt),
        .id_uses_rt_i (pif.id_uses_rt),
        .ex_memrd_i   (pif.ex_memrd),
        .ex_rt_i      (pif.ex_rt),
        .lu_o         (lu)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            hold_q     <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        irq_take  = 1'b0;

        if (pif.mem_busy) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            // IRQ_HOLD is kept with its counter frozen rather than entering MEM_WAIT
            if (state_q == RUN) state_d = MEM_WAIT;
        end else begin
            if (state_q == MEM_WAIT) begin
                state_d = RUN;
            end else if (state_q == IRQ_HOLD) begin
                hold_d = hold_q - 4'd1;
                if (hold_q <= 4'd1) begin
                    state_d = RUN;
                    hold_d  = '0;
                end
            end

            if (pif.ex_br_taken) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (lu) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end else if (pif.id_pcsrc == PCSRC_J || pif.id_pcsrc == PCSRC_JR) begin
                flush_id = 1'b1;
            end else if (state_q == RUN && irq_pend_q && !pif.pc31_id &&
                         pif.id_pcsrc != PCSRC_BR) begin
                irq_take = 1'b1;
                flush_id = 1'b1;
                state_d  = IRQ_HOLD;
                hold_d   = 4'(HOLDOFF);
            end
        end

        irq_pend_d = !irq_take && (irq_pend_q || (pif.irq_in && !pif.pc31_id));
    end

    assign pif.stall_if  = stall_if;
    assign pif.stall_id  = stall_id;
    assign pif.stall_ex  = stall_ex;
    assign pif.stall_mem = stall_mem;
    assign pif.flush_id  = flush_id;
    assign pif.flush_ex  = flush_ex;
    assign pif.irq_take  = irq_take;
    assign pif.irq_pend  = irq_pend_q;

`ifdef PIPE_SEQ_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_if)             stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_id || flush_ex) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign pif.stall_cnt = stall_cnt_q;
    assign pif.flush_cnt = flush_cnt_q;
`else
    assign pif.stall_cnt = '0;
    assign pif.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed-vector bench for pipe_sequencer (HOLDOFF = 3); counter checks
// follow PIPE_SEQ_PERF_EN.
module tb_pipe_sequencer;
    import pipe_seq_pkg::*;

    // strobe vector: {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, irq_take}
    localparam logic [6:0] S_0    = 7'b0000000;
    localparam logic [6:0] S_LU   = 7'b1100010;
    localparam logic [6:0] S_MEM  = 7'b1111000;
    localparam logic [6:0] S_BR   = 7'b0000110;
    localparam logic [6:0] S_J    = 7'b0000100;
    localparam logic [6:0] S_TAKE = 7'b0000101;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    logic [31:0] exp_stall, exp_flush;

    always #5 clk = ~clk;

    pipe_seq_if pif ();

    pipe_sequencer #(.HOLDOFF(3)) dut (
        .clk   (clk),
        .reset (reset),
        .pif   (pif)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {pif.stall_if, pif.stall_id, pif.stall_ex, pif.stall_mem,
                pif.flush_id, pif.flush_ex, pif.irq_take};
    endfunction

    task automatic idle();
        pif.id_rs       = '0;
        pif.id_rt       = '0;
        pif.id_uses_rt  = 1'b0;
        pif.id_pcsrc    = PCSRC_SEQ;
        pif.ex_memrd    = 1'b0;
        pif.ex_rt       = '0;
        pif.ex_br_taken = 1'b0;
        pif.mem_busy    = 1'b0;
        pif.irq_in      = 1'b0;
        pif.pc31_id     = 1'b0;
    endtask

    // Inputs are already applied; check mid-cycle, then advance past the edge.
    task automatic cyc(input string tag, input logic [6:0] exp_s, input logic exp_pend);
        @(negedge clk);
        check({tag, "/strobes"}, {25'b0, strobes()}, {25'b0, exp_s});
        check({tag, "/pend"}, {31'b0, pif.irq_pend}, {31'b0, exp_pend});
        if (exp_s[6])            exp_stall++;
        if (exp_s[2] | exp_s[1]) exp_flush++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef PIPE_SEQ_PERF_EN
        check({tag, "/stall_cnt"}, pif.stall_cnt, exp_stall);
        check({tag, "/flush_cnt"}, pif.flush_cnt, exp_flush);
`else
        check({tag, "/stall_cnt"}, pif.stall_cnt, 32'd0);
        check({tag, "/flush_cnt"}, pif.flush_cnt, 32'd0);
`endif
    endtask

    initial begin
        idle();
        exp_stall = '0;
        exp_flush = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst/strobes", {25'b0, strobes()}, 32'd0);
        check("rst/pend", {31'b0, pif.irq_pend}, 32'd0);
        chk_cnt("rst");
        reset = 1'b1;

        // load-use hazards
        pif.ex_memrd = 1'b1; pif.ex_rt = 5'd8; pif.id_rs = 5'd8;
        cyc("lu_rs", S_LU, 1'b0);
        idle();
        cyc("lu_gone", S_0, 1'b0);
        pif.ex_memrd = 1'b1; pif.ex_rt = 5'd0; pif.id_rs = 5'd0;
        cyc("lu_r0", S_0, 1'b0);
        pif.ex_rt = 5'd9; pif.id_rt = 5'd9; pif.id_rs = 5'd3; pif.id_uses_rt = 1'b1;
        cyc("lu_rt", S_LU, 1'b0);
        pif.id_uses_rt = 1'b0;
        cyc("lu_rt_unused", S_0, 1'b0);
        pif.id_uses_rt = 1'b1; pif.ex_br_taken = 1'b1;
        cyc("br_over_lu", S_BR, 1'b0);

        // jumps
        idle(); pif.id_pcsrc = PCSRC_J;
        cyc("j", S_J, 1'b0);
        pif.id_pcsrc = PCSRC_JR;
        cyc("jr", S_J, 1'b0);
        pif.ex_br_taken = 1'b1;
        cyc("br_over_jr", S_BR, 1'b0);
        chk_cnt("hazards");

        // memory wait with an irq arriving; take deferred until back in RUN
        idle(); pif.mem_busy = 1'b1; pif.irq_in = 1'b1;
        cyc("mem1", S_MEM, 1'b0);
        pif.irq_in = 1'b0;
        cyc("mem2", S_MEM, 1'b1);
        cyc("mem3", S_MEM, 1'b1);
        cyc("mem4", S_MEM, 1'b1);
        pif.mem_busy = 1'b0;
        cyc("mem_exit", S_0, 1'b1);
        cyc("take1", S_TAKE, 1'b1);

        // holdoff: second irq waits HOLDOFF cycles
        pif.irq_in = 1'b1;
        cyc("hold1", S_0, 1'b0);
        pif.irq_in = 1'b0;
        cyc("hold2", S_0, 1'b1);
        cyc("hold3", S_0, 1'b1);
        cyc("take2", S_TAKE, 1'b1);

        // mem_busy in holdoff freezes the counter
        pif.mem_busy = 1'b1; pif.irq_in = 1'b1;
        cyc("hold_busy", S_MEM, 1'b0);
        idle();
        cyc("hold_f1", S_0, 1'b1);
        cyc("hold_f2", S_0, 1'b1);
        cyc("hold_f3", S_0, 1'b1);
        cyc("take3", S_TAKE, 1'b1);

        // kernel mode masks the latch
        pif.pc31_id = 1'b1; pif.irq_in = 1'b1;
        cyc("kmask", S_0, 1'b0);
        idle();
        cyc("kmask_pend", S_0, 1'b0);
        cyc("hold_end", S_0, 1'b0);

        // branch in ID and kernel-mode ID defer the take
        pif.irq_in = 1'b1;
        cyc("irq_set", S_0, 1'b0);
        pif.irq_in = 1'b0; pif.id_pcsrc = PCSRC_BR;
        cyc("defer_br1", S_0, 1'b1);
        cyc("defer_br2", S_0, 1'b1);
        pif.id_pcsrc = PCSRC_SEQ; pif.pc31_id = 1'b1;
        cyc("defer_k", S_0, 1'b1);
        idle();
        cyc("take4", S_TAKE, 1'b1);
        chk_cnt("irq");

        // reset during holdoff with a new irq pending
        pif.irq_in = 1'b1;
        cyc("hold_pend", S_0, 1'b0);
        idle();
        #2 reset = 1'b0;
        #1;
        exp_stall = '0;
        exp_flush = '0;
        check("rst_mid/strobes", {25'b0, strobes()}, 32'd0);
        check("rst_mid/pend", {31'b0, pif.irq_pend}, 32'd0);
        chk_cnt("rst_mid");
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc("post_rst", S_0, 1'b0);
        pif.irq_in = 1'b1;
        cyc("irq_after_rst", S_0, 1'b0);
        idle();
        cyc("take_after_rst", S_TAKE, 1'b1);
        cyc("after_take", S_0, 1'b0);
        chk_cnt("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
